// File: rtl/axil_fifo_bridge_pkg.sv
// Shared address map, AXI response codes and FSM state types for axil_fifo_bridge.
// Optional error responses are enabled by defining AXIL_FIFO_BRIDGE_ERR_EN.
package axil_fifo_bridge_pkg;

   localparam logic [9:0] CSR_BASE   = 10'h000;
   localparam logic [9:0] PS2PL_DATA = 10'h100;
   localparam logic [9:0] PS2PL_FREE = 10'h104;
   localparam logic [9:0] PL2PS_DATA = 10'h108;
   localparam logic [9:0] PL2PS_CNT  = 10'h10C;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXIL_FIFO_BRIDGE_ERR_EN
   localparam logic [1:0] RESP_ERR = RESP_SLVERR;
`else
   localparam logic [1:0] RESP_ERR = RESP_OKAY;
`endif

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
   typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_e;

   function automatic logic [7:0] word_idx(input logic [9:0] byte_addr);
      return byte_addr[9:2];
   endfunction

endpackage

// File: rtl/axil_fifo_bridge_fifo.sv
// Registered 1r1w word FIFO; head data reads as zero while empty.
module axil_fifo_bridge_fifo #(
   parameter int unsigned els_p   = 8,
   parameter int unsigned width_p = 32
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      push_v_i,
   input  logic [width_p-1:0]        push_data_i,
   output logic                      full_o,
   output logic                      v_o,
   output logic [width_p-1:0]        data_o,
   input  logic                      yumi_i,
   output logic [$clog2(els_p):0]    count_o
);

   localparam int unsigned AW = $clog2(els_p);
   localparam int unsigned PW = AW + 1;

   logic [width_p-1:0] mem_q [els_p];
   logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic               push, pop;

   assign count_o = wptr_q - rptr_q;
   assign full_o  = (count_o == PW'(els_p));
   assign v_o     = (count_o != '0);
   assign data_o  = v_o ? mem_q[rptr_q[AW-1:0]] : '0;

   assign push = push_v_i & ~full_o;
   assign pop  = yumi_i & v_o;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/axil_fifo_bridge.sv
// AXI-lite slave exposing byte-writable CSRs plus ps2pl/pl2ps word FIFOs to PL logic.
// Define AXIL_FIFO_BRIDGE_ERR_EN to return SLVERR on unmapped/illegal accesses.
module axil_fifo_bridge
   import axil_fifo_bridge_pkg::*;
#(
   parameter int C_S00_AXI_DATA_WIDTH = 32,
   parameter int C_S00_AXI_ADDR_WIDTH = 10,
   parameter int num_regs_p           = 4,
   parameter int fifo_els_p           = 8
) (
   input  logic                                aclk,
   input  logic                                aresetn,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic [2:0]                          s00_axi_awprot,
   input  logic                                s00_axi_awvalid,
   output logic                                s00_axi_awready,
   input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
   input  logic                                s00_axi_wvalid,
   output logic                                s00_axi_wready,
   output logic [1:0]                          s00_axi_bresp,
   output logic                                s00_axi_bvalid,
   input  logic                                s00_axi_bready,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic [2:0]                          s00_axi_arprot,
   input  logic                                s00_axi_arvalid,
   output logic                                s00_axi_arready,
   output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                          s00_axi_rresp,
   output logic                                s00_axi_rvalid,
   input  logic                                s00_axi_rready,
   output logic [num_regs_p*32-1:0]            csr_o,
   output logic                                ps2pl_v_o,
   output logic [31:0]                         ps2pl_data_o,
   input  logic                                ps2pl_yumi_i,
   input  logic                                pl2ps_v_i,
   input  logic [31:0]                         pl2ps_data_i,
   output logic                                pl2ps_ready_o
);

   localparam int unsigned PW = $clog2(fifo_els_p) + 1;
   localparam logic [PW-1:0] ELS = PW'(fifo_els_p);

   w_state_e w_state_q, w_state_d;
   r_state_e r_state_q, r_state_d;
   logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
   logic [31:0] rdata_q, rdata_d, rd_word;
   logic [num_regs_p*32-1:0] csr_q, csr_d;
   logic [9:0]  aw_a, ar_a;
   logic [7:0]  aw_idx, ar_idx;
   logic        w_acc, r_acc, aw_csr, aw_push, ar_csr, wr_err, rd_err;
   logic        ps2pl_full, pl2ps_full, pl2ps_v, pl2ps_pop;
   logic [PW-1:0] ps2pl_cnt, pl2ps_cnt;
   logic [31:0] pl2ps_head;
   logic        unused_ok;

   assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

   assign aw_a    = 10'(s00_axi_awaddr);
   assign ar_a    = 10'(s00_axi_araddr);
   assign aw_idx  = word_idx(aw_a);
   assign ar_idx  = word_idx(ar_a);
   assign aw_csr  = aw_idx < 8'(num_regs_p);
   assign ar_csr  = ar_idx < 8'(num_regs_p);
   assign aw_push = aw_idx == word_idx(PS2PL_DATA);

   // Ready strobes are combinational so AW/W are taken in the same cycle only.
   assign w_acc = aresetn & (w_state_q == W_IDLE) & s00_axi_awvalid & s00_axi_wvalid;
   assign r_acc = aresetn & (r_state_q == R_IDLE) & s00_axi_arvalid;

   assign s00_axi_awready = w_acc;
   assign s00_axi_wready  = w_acc;
   assign s00_axi_arready = r_acc;
   assign s00_axi_bvalid  = (w_state_q == W_RESP);
   assign s00_axi_rvalid  = (r_state_q == R_RESP);
   assign s00_axi_bresp   = bresp_q;
   assign s00_axi_rresp   = rresp_q;
   assign s00_axi_rdata   = C_S00_AXI_DATA_WIDTH'(rdata_q);
   assign csr_o           = csr_q;
   assign pl2ps_ready_o   = aresetn & ~pl2ps_full;

   assign wr_err    = (~aw_csr & ~aw_push) | (aw_push & ps2pl_full);
   assign pl2ps_pop = r_acc & (ar_idx == word_idx(PL2PS_DATA)) & pl2ps_v;

   always_comb begin
      w_state_d = w_state_q;
      bresp_d   = bresp_q;
      csr_d     = csr_q;
      case (w_state_q)
         W_IDLE: if (w_acc) begin
            w_state_d = W_RESP;
            bresp_d   = wr_err ? RESP_ERR : RESP_OKAY;
            for (int unsigned i = 0; i < num_regs_p; i++)
               if (aw_csr && aw_idx == 8'(i))
                  for (int unsigned b = 0; b < 4; b++)
                     if (s00_axi_wstrb[b]) csr_d[32*i+8*b +: 8] = s00_axi_wdata[8*b +: 8];
         end
         W_RESP: if (s00_axi_bready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      rd_word = '0;
      rd_err  = 1'b0;
      if (ar_csr) begin
         for (int unsigned i = 0; i < num_regs_p; i++)
            if (ar_idx == 8'(i)) rd_word = csr_q[32*i +: 32];
      end else if (ar_idx == word_idx(PS2PL_FREE)) begin
         rd_word = 32'(ELS - ps2pl_cnt);
      end else if (ar_idx == word_idx(PL2PS_DATA)) begin
         rd_word = pl2ps_head;
         rd_err  = ~pl2ps_v;
      end else if (ar_idx == word_idx(PL2PS_CNT)) begin
         rd_word = 32'(pl2ps_cnt);
      end else begin
         rd_err  = 1'b1;
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: if (r_acc) begin
            r_state_d = R_RESP;
            rdata_d   = rd_word;
            rresp_d   = rd_err ? RESP_ERR : RESP_OKAY;
         end
         R_RESP: if (s00_axi_rready) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         bresp_q   <= RESP_OKAY;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         csr_q     <= '0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         bresp_q   <= bresp_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         csr_q     <= csr_d;
      end
   end

   axil_fifo_bridge_fifo #(.els_p(fifo_els_p), .width_p(32)) ps2pl_fifo (
      .clk_i      (aclk),
      .reset_n_i  (aresetn),
      .push_v_i   (w_acc & aw_push),
      .push_data_i(s00_axi_wdata[31:0]),
      .full_o     (ps2pl_full),
      .v_o        (ps2pl_v_o),
      .data_o     (ps2pl_data_o),
      .yumi_i     (ps2pl_yumi_i),
      .count_o    (ps2pl_cnt)
   );

   axil_fifo_bridge_fifo #(.els_p(fifo_els_p), .width_p(32)) pl2ps_fifo (
      .clk_i      (aclk),
      .reset_n_i  (aresetn),
      .push_v_i   (pl2ps_v_i & pl2ps_ready_o),
      .push_data_i(pl2ps_data_i),
      .full_o     (pl2ps_full),
      .v_o        (pl2ps_v),
      .data_o     (pl2ps_head),
      .yumi_i     (pl2ps_pop),
      .count_o    (pl2ps_cnt)
   );

endmodule

// File: tb/tb_axil_fifo_bridge.sv
// Self-checking bench for axil_fifo_bridge; honours AXIL_FIFO_BRIDGE_ERR_EN for expected responses.
module tb_axil_fifo_bridge;

`ifdef AXIL_FIFO_BRIDGE_ERR_EN
   localparam logic [1:0] ERR_RESP = 2'b10;
`else
   localparam logic [1:0] ERR_RESP = 2'b00;
`endif
   localparam logic [1:0] OKAY = 2'b00;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [9:0]  s00_axi_awaddr, s00_axi_araddr;
   logic [2:0]  s00_axi_awprot, s00_axi_arprot;
   logic        s00_axi_awvalid, s00_axi_awready, s00_axi_wvalid, s00_axi_wready;
   logic [31:0] s00_axi_wdata, s00_axi_rdata;
   logic [3:0]  s00_axi_wstrb;
   logic [1:0]  s00_axi_bresp, s00_axi_rresp;
   logic        s00_axi_bvalid, s00_axi_bready, s00_axi_arvalid, s00_axi_arready;
   logic        s00_axi_rvalid, s00_axi_rready;
   logic [127:0] csr_o;
   logic        ps2pl_v_o, ps2pl_yumi_i, pl2ps_v_i, pl2ps_ready_o;
   logic [31:0] ps2pl_data_o, pl2ps_data_i;

   typedef struct packed { logic [31:0] d; logic [1:0] r; } exp_t;
   exp_t        exp_q[$];
   logic [31:0] word_q[$];
   int          checks = 0;
   int          errors = 0;

   always #5 aclk = ~aclk;

   axil_fifo_bridge #(
      .C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(10), .num_regs_p(4), .fifo_els_p(8)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s00_axi_awaddr(s00_axi_awaddr), .s00_axi_awprot(s00_axi_awprot),
      .s00_axi_awvalid(s00_axi_awvalid), .s00_axi_awready(s00_axi_awready),
      .s00_axi_wdata(s00_axi_wdata), .s00_axi_wstrb(s00_axi_wstrb),
      .s00_axi_wvalid(s00_axi_wvalid), .s00_axi_wready(s00_axi_wready),
      .s00_axi_bresp(s00_axi_bresp), .s00_axi_bvalid(s00_axi_bvalid), .s00_axi_bready(s00_axi_bready),
      .s00_axi_araddr(s00_axi_araddr), .s00_axi_arprot(s00_axi_arprot),
      .s00_axi_arvalid(s00_axi_arvalid), .s00_axi_arready(s00_axi_arready),
      .s00_axi_rdata(s00_axi_rdata), .s00_axi_rresp(s00_axi_rresp),
      .s00_axi_rvalid(s00_axi_rvalid), .s00_axi_rready(s00_axi_rready),
      .csr_o(csr_o), .ps2pl_v_o(ps2pl_v_o), .ps2pl_data_o(ps2pl_data_o), .ps2pl_yumi_i(ps2pl_yumi_i),
      .pl2ps_v_i(pl2ps_v_i), .pl2ps_data_i(pl2ps_data_i), .pl2ps_ready_o(pl2ps_ready_o)
   );

   task automatic axi_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
      int n;
      @(negedge aclk);
      s00_axi_awaddr = a; s00_axi_wdata = d; s00_axi_wstrb = s;
      s00_axi_awvalid = 1'b1; s00_axi_wvalid = 1'b1; s00_axi_bready = 1'b1;
      #1 n = 0;
      while (!(s00_axi_awready && s00_axi_wready) && n < 20) begin @(negedge aclk); #1 n++; end
      if (n >= 20) begin
         checks++; errors++;
         $display("FAIL aw_accept_timeout addr=%h got no awready, required awready=1", a);
         s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0; resp = 2'b11; lat = -1;
         return;
      end
      @(posedge aclk); #1;
      s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0;
      lat = 1;
      while (!s00_axi_bvalid && lat < 20) begin @(posedge aclk); #1 lat++; end
      resp = s00_axi_bresp;
      @(posedge aclk); #1;
   endtask

   task automatic axi_read(input logic [9:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      @(negedge aclk);
      s00_axi_araddr = a; s00_axi_arvalid = 1'b1; s00_axi_rready = 1'b1;
      #1 n = 0;
      while (!s00_axi_arready && n < 20) begin @(negedge aclk); #1 n++; end
      if (n >= 20) begin
         checks++; errors++;
         $display("FAIL ar_accept_timeout addr=%h got no arready, required arready=1", a);
         s00_axi_arvalid = 1'b0; d = 'x; resp = 2'b11;
         return;
      end
      @(posedge aclk); #1;
      s00_axi_arvalid = 1'b0;
      n = 0;
      while (!s00_axi_rvalid && n < 20) begin @(posedge aclk); #1 n++; end
      d = s00_axi_rdata; resp = s00_axi_rresp;
      @(posedge aclk); #1;
   endtask

   task automatic pl_push(input logic [31:0] d);
      @(negedge aclk);
      pl2ps_v_i = 1'b1; pl2ps_data_i = d;
      @(posedge aclk); #1 pl2ps_v_i = 1'b0;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      s00_axi_awvalid = 1'b1; s00_axi_wvalid = 1'b1; s00_axi_arvalid = 1'b1;
      repeat (10) @(posedge aclk);
      @(negedge aclk);
      checks++;
      if ({s00_axi_awready, s00_axi_wready, s00_axi_arready, s00_axi_bvalid, s00_axi_rvalid,
           s00_axi_bresp, s00_axi_rresp, s00_axi_rdata, csr_o, ps2pl_v_o, pl2ps_ready_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got aw%b w%b ar%b b%b r%b rdy%b csr=%h, required all 0",
                  s00_axi_awready, s00_axi_wready, s00_axi_arready, s00_axi_bvalid, s00_axi_rvalid,
                  pl2ps_ready_o, csr_o);
      end
      s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0; s00_axi_arvalid = 1'b0;
      aresetn = 1'b1;
      @(negedge aclk);
      checks++;
      if ({s00_axi_awready, s00_axi_wready, s00_axi_arready, s00_axi_bvalid, s00_axi_rvalid,
           s00_axi_bresp, s00_axi_rresp, s00_axi_rdata, csr_o, ps2pl_v_o, ps2pl_data_o, pl2ps_ready_o}
          !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 128'h0, 1'b0, 32'h0, 1'b1}) begin
         errors++;
         $display("FAIL idle_outputs got ready=%b v=%b csr=%h, required pl2ps_ready_o=1 and rest 0",
                  pl2ps_ready_o, ps2pl_v_o, csr_o);
      end
      begin
         logic [31:0] d; logic [1:0] r; exp_t e;
         exp_q.push_back('{d: 32'd8, r: OKAY});
         axi_read(10'h104, d, r);
         e = exp_q.pop_front(); checks++;
         if ({d, r} !== e) begin errors++; $display("FAIL reset_free got %h/%b, required %h/%b", d, r, e.d, e.r); end
         exp_q.push_back('{d: 32'd0, r: OKAY});
         axi_read(10'h10C, d, r);
         e = exp_q.pop_front(); checks++;
         if ({d, r} !== e) begin errors++; $display("FAIL reset_cnt got %h/%b, required %h/%b", d, r, e.d, e.r); end
      end
   endtask

   task automatic test_csr();
      logic [31:0] d; logic [1:0] r; int lat; exp_t e;
      axi_write(10'h004, 32'hDEADBEEF, 4'hF, r, lat);
      checks++;
      if (lat !== 1 || r !== OKAY) begin errors++; $display("FAIL csr_write_lat got lat=%0d resp=%b, required lat=1 resp=00", lat, r); end
      axi_write(10'h004, 32'h00000011, 4'b0001, r, lat);
      exp_q.push_back('{d: 32'hDEADBE11, r: OKAY});
      axi_read(10'h004, d, r);
      e = exp_q.pop_front(); checks++;
      if ({d, r} !== e) begin errors++; $display("FAIL csr_strb got %h/%b, required %h/%b", d, r, e.d, e.r); end
      checks++;
      if (csr_o[63:32] !== 32'hDEADBE11) begin errors++; $display("FAIL csr_o1 got %h, required deadbe11", csr_o[63:32]); end
      axi_write(10'h104, 32'h55, 4'hF, r, lat);
      checks++;
      if (r !== ERR_RESP) begin errors++; $display("FAIL ro_write_resp got %b, required %b", r, ERR_RESP); end
      exp_q.push_back('{d: 32'd8, r: OKAY});
      exp_q.push_back('{d: 32'd0, r: ERR_RESP});
      exp_q.push_back('{d: 32'd0, r: ERR_RESP});
      axi_read(10'h104, d, r);
      e = exp_q.pop_front(); checks++;
      if ({d, r} !== e) begin errors++; $display("FAIL ro_unchanged got %h/%b, required %h/%b", d, r, e.d, e.r); end
      axi_read(10'h1F0, d, r);
      e = exp_q.pop_front(); checks++;
      if ({d, r} !== e) begin errors++; $display("FAIL unmapped_read got %h/%b, required %h/%b", d, r, e.d, e.r); end
      axi_read(10'h100, d, r);
      e = exp_q.pop_front(); checks++;
      if ({d, r} !== e) begin errors++; $display("FAIL wo_read got %h/%b, required %h/%b", d, r, e.d, e.r); end
   endtask

   task automatic test_ps2pl_fill();
      logic [31:0] d; logic [1:0] r; int lat; exp_t e; logic [31:0] w;
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back('{d: 32'(i), r: (word_q.size() < 8) ? OKAY : ERR_RESP});
         if (word_q.size() < 8) word_q.push_back(32'(i));
         axi_write(10'h100, 32'(i), 4'b0000, r, lat);
         e = exp_q.pop_front(); checks++;
         if (r !== e.r) begin errors++; $display("FAIL ps2pl_push_resp word=%0d got %b, required %b", i, r, e.r); end
      end
      exp_q.push_back('{d: 32'd0, r: OKAY});
      axi_read(10'h104, d, r);
      e = exp_q.pop_front(); checks++;
      if ({d, r} !== e) begin errors++; $display("FAIL ps2pl_free_full got %h/%b, required %h/%b", d, r, e.d, e.r); end
      while (word_q.size() > 0) begin
         w = word_q.pop_front();
         @(negedge aclk); checks++;
         if ({ps2pl_v_o, ps2pl_data_o} !== {1'b1, w}) begin
            errors++; $display("FAIL ps2pl_pop got v=%b %h, required v=1 %h", ps2pl_v_o, ps2pl_data_o, w);
         end
         ps2pl_yumi_i = ps2pl_v_o;
         @(posedge aclk); #1 ps2pl_yumi_i = 1'b0;
      end
      @(negedge aclk); checks++;
      if (ps2pl_v_o !== 1'b0) begin errors++; $display("FAIL ps2pl_drained got v=%b, required 0", ps2pl_v_o); end
   endtask

   task automatic test_pl2ps();
      logic [31:0] d; logic [1:0] r; exp_t e;
      pl_push(32'hA5); word_q.push_back(32'hA5);
      pl_push(32'h5A); word_q.push_back(32'h5A);
      exp_q.push_back('{d: 32'd2, r: OKAY});
      axi_read(10'h10C, d, r);
      e = exp_q.pop_front(); checks++;
      if ({d, r} !== e) begin errors++; $display("FAIL pl2ps_cnt got %h/%b, required %h/%b", d, r, e.d, e.r); end
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back((word_q.size() > 0) ? '{d: word_q.pop_front(), r: OKAY} : '{d: 32'd0, r: ERR_RESP});
         axi_read(10'h108, d, r);
         e = exp_q.pop_front(); checks++;
         if ({d, r} !== e) begin errors++; $display("FAIL pl2ps_pop%0d got %h/%b, required %h/%b", i, d, r, e.d, e.r); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d; logic [1:0] r; exp_t e;
      @(negedge aclk);
      s00_axi_awaddr = 10'h008; s00_axi_wdata = 32'h12345678; s00_axi_wstrb = 4'hF;
      s00_axi_awvalid = 1'b1; s00_axi_wvalid = 1'b1; s00_axi_araddr = 10'h004; s00_axi_arvalid = 1'b1;
      s00_axi_bready = 1'b0; s00_axi_rready = 1'b0;
      #1 checks++;
      if ({s00_axi_awready, s00_axi_wready, s00_axi_arready} !== 3'b111) begin
         errors++; $display("FAIL dual_accept got %b, required 111", {s00_axi_awready, s00_axi_wready, s00_axi_arready});
      end
      @(posedge aclk);
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk); checks++;
         if ({s00_axi_bvalid, s00_axi_rvalid, s00_axi_awready, s00_axi_arready, s00_axi_bresp, s00_axi_rresp, s00_axi_rdata}
             !== {4'b1100, OKAY, OKAY, 32'hDEADBE11}) begin
            errors++; $display("FAIL hold_cycle%0d got bv=%b rv=%b awr=%b arr=%b rdata=%h, required 1 1 0 0 deadbe11",
                               i, s00_axi_bvalid, s00_axi_rvalid, s00_axi_awready, s00_axi_arready, s00_axi_rdata);
         end
      end
      s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0; s00_axi_arvalid = 1'b0;
      s00_axi_bready = 1'b1; s00_axi_rready = 1'b1;
      @(posedge aclk); #1 checks++;
      if ({s00_axi_bvalid, s00_axi_rvalid} !== 2'b00) begin
         errors++; $display("FAIL hold_release got bv=%b rv=%b, required 0 0", s00_axi_bvalid, s00_axi_rvalid);
      end
      exp_q.push_back('{d: 32'h12345678, r: OKAY});
      axi_read(10'h008, d, r);
      e = exp_q.pop_front(); checks++;
      if ({d, r} !== e) begin errors++; $display("FAIL dual_write_csr2 got %h/%b, required %h/%b", d, r, e.d, e.r); end
   endtask

   task automatic test_reset_mid_write();
      logic [31:0] d; logic [1:0] r; int lat; exp_t e;
      axi_write(10'h100, 32'h77, 4'hF, r, lat);
      pl_push(32'h99);
      @(negedge aclk);
      s00_axi_awaddr = 10'h000; s00_axi_wdata = 32'hCAFE; s00_axi_wstrb = 4'hF;
      s00_axi_awvalid = 1'b1; s00_axi_wvalid = 1'b1; s00_axi_bready = 1'b0;
      @(posedge aclk); #1 s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0;
      checks++;
      if (s00_axi_bvalid !== 1'b1) begin errors++; $display("FAIL wresp_entered got bvalid=%b, required 1", s00_axi_bvalid); end
      aresetn = 1'b0;
      repeat (2) @(posedge aclk);
      @(negedge aclk); aresetn = 1'b1; s00_axi_bready = 1'b1;
      @(negedge aclk); checks++;
      if ({s00_axi_bvalid, ps2pl_v_o, csr_o, pl2ps_ready_o} !== {1'b0, 1'b0, 128'h0, 1'b1}) begin
         errors++; $display("FAIL mid_reset got bv=%b v=%b csr=%h rdy=%b, required 0 0 0 1",
                            s00_axi_bvalid, ps2pl_v_o, csr_o, pl2ps_ready_o);
      end
      exp_q.push_back('{d: 32'd0, r: OKAY});
      axi_read(10'h10C, d, r);
      e = exp_q.pop_front(); checks++;
      if ({d, r} !== e) begin errors++; $display("FAIL mid_reset_cnt got %h/%b, required %h/%b", d, r, e.d, e.r); end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout sim time exceeded, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      s00_axi_awaddr = '0; s00_axi_araddr = '0; s00_axi_awprot = '0; s00_axi_arprot = '0;
      s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0; s00_axi_wdata = '0; s00_axi_wstrb = '0;
      s00_axi_bready = 1'b1; s00_axi_arvalid = 1'b0; s00_axi_rready = 1'b1;
      ps2pl_yumi_i = 1'b0; pl2ps_v_i = 1'b0; pl2ps_data_i = '0;
      test_reset();
      test_csr();
      test_ps2pl_fill();
      test_pl2ps();
      test_back_to_back();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
